// File: rtl/dropout_layer_lfsr.sv
// Dropout stage for the speech NN: per-lane Galois LFSRs pick channels to zero in
// train mode, kept channels are rescaled by keep_scale (Q2.16, round half up, saturating).
module dropout_layer_lfsr #(
  parameter int          DATA_W    = 60,
  parameter int          CHANNELS  = 16,
  parameter int          LANES     = 4,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [CHANNELS-1:0][DATA_W-1:0]        in_vec,
  input  logic                                   train_en,
  input  logic [15:0]                            drop_thresh,
  input  logic [17:0]                            keep_scale,
  input  logic                                   seed_load,
  input  logic [31:0]                            seed_val,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [CHANNELS-1:0][DATA_W-1:0]        out_vec,
  output logic [CHANNELS-1:0]                    keep_mask,
  output logic [$clog2(CHANNELS+1)-1:0]          drop_count,
  output logic [1:0]                             dbg_state
);

  localparam int BEATS  = CHANNELS / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int DC_W   = $clog2(CHANNELS + 1);
  localparam int PW     = DATA_W + 19;
  localparam logic [31:0] TAPS = 32'h8020_0003;
  localparam logic signed [PW-1:0] Y_MAX = $signed({{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
  localparam logic signed [PW-1:0] Y_MIN = $signed({{(PW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}});

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PROC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef logic [CHANNELS-1:0][DATA_W-1:0] vec_t;

  function automatic logic [31:0] lane_seed(input logic [31:0] base, input int lane);
    logic [31:0] v;
    v = base ^ (32'(lane) * 32'h9E37_79B9);
    return (v == 32'h0) ? 32'h1 : v;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  logic [1:0]              state_q, state_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  vec_t                    in_q, in_d;
  vec_t                    vec_q, vec_d;
  logic [CHANNELS-1:0]     mask_q, mask_d;
  logic [DC_W-1:0]         cnt_q, cnt_d;
  logic                    train_q, train_d;
  logic [15:0]             thresh_q, thresh_d;
  logic [17:0]             scale_q, scale_d;
  logic [LANES-1:0][31:0]  lfsr_q, lfsr_d;

  logic [LANES-1:0][DATA_W-1:0] lane_y;
  logic [LANES-1:0]             lane_keep;
  logic [DC_W-1:0]              beat_drops;
  logic signed [PW-1:0]         prod, y_full;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid never waits on ready, and outputs hold while out_valid && !out_ready.
  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign out_vec    = vec_q;
  assign keep_mask  = mask_q;
  assign drop_count = cnt_q;
  assign dbg_state  = state_q;

  // The current beat's channels always sit in the low LANES slots of in_q.
  always_comb begin
    lane_y     = '0;
    lane_keep  = '0;
    beat_drops = '0;
    prod       = '0;
    y_full     = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_keep[l] = !(train_q && (lfsr_q[l][31:16] < thresh_q));
      prod   = PW'($signed(in_q[l])) * PW'($signed({1'b0, scale_q}));
      y_full = (prod + PW'(32'sd32768)) >>> 16;
      if (!lane_keep[l])     lane_y[l] = '0;
      else if (!train_q)     lane_y[l] = in_q[l];
      else if (y_full > Y_MAX) lane_y[l] = Y_MAX[DATA_W-1:0];
      else if (y_full < Y_MIN) lane_y[l] = Y_MIN[DATA_W-1:0];
      else                   lane_y[l] = y_full[DATA_W-1:0];
      beat_drops = beat_drops + DC_W'(!lane_keep[l]);
    end
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    in_d     = in_q;
    vec_d    = vec_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    train_d  = train_q;
    thresh_d = thresh_q;
    scale_d  = scale_q;
    lfsr_d   = lfsr_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          in_d     = in_vec;
          train_d  = train_en;
          thresh_d = drop_thresh;
          scale_d  = keep_scale;
          beat_d   = '0;
          cnt_d    = '0;
          state_d  = ST_PROC;
        end else if (seed_load) begin
          for (int l = 0; l < LANES; l++)
            lfsr_d[l] = lane_seed((seed_val == 32'h0) ? LFSR_SEED : seed_val, l);
        end
      end
      ST_PROC: begin
        // Results enter at the top and shift down, so after BEATS beats channel c is at slot c.
        in_d   = in_q >> (LANES * DATA_W);
        vec_d  = vec_q >> (LANES * DATA_W);
        mask_d = mask_q >> LANES;
        for (int l = 0; l < LANES; l++) begin
          vec_d[CHANNELS-LANES+l]  = lane_y[l];
          mask_d[CHANNELS-LANES+l] = lane_keep[l];
          lfsr_d[l]                = lfsr_step(lfsr_q[l]);
        end
        cnt_d  = cnt_q + beat_drops;
        beat_d = beat_q + BEAT_W'(1);
        if (beat_q == BEAT_W'(BEATS - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      beat_q   <= '0;
      in_q     <= '0;
      vec_q    <= '0;
      mask_q   <= '0;
      cnt_q    <= '0;
      train_q  <= 1'b0;
      thresh_q <= '0;
      scale_q  <= '0;
      for (int l = 0; l < LANES; l++) lfsr_q[l] <= lane_seed(LFSR_SEED, l);
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      in_q     <= in_d;
      vec_q    <= vec_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      train_q  <= train_d;
      thresh_q <= thresh_d;
      scale_q  <= scale_d;
      lfsr_q   <= lfsr_d;
    end
  end

endmodule
